// File: rtl/blit_cmd_queue.sv
// Command queue feeding the blitter decoder: assembles CPU argument/command
// writes into 104-bit commands, buffers them in a FIFO and exposes a status register.
module blit_cmd_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_write,
  input  logic          cpu_read,
  input  logic [2:0]    cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_wait,
  output logic [103:0]  p0_cmd,
  output logic          p0_cmd_valid,
  input  logic          cmd_next,
  input  logic          stall,
  input  logic          blit_active
);

  localparam int CMD_W = 104;

  localparam logic [2:0] ADDR_ARG0   = 3'd0;
  localparam logic [2:0] ADDR_ARG1   = 3'd1;
  localparam logic [2:0] ADDR_ARG2   = 3'd2;
  localparam logic [2:0] ADDR_CMD    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  logic [31:0]      arg0;
  logic [31:0]      arg1;
  logic [31:0]      arg2;
  logic [CMD_W-1:0] fifo_mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             cmd_wr;
  logic             push;
  logic             pop;
  logic             busy;

  function automatic logic [31:0] pack_status(input logic [AW:0] cnt,
                                              input logic        full_f,
                                              input logic        busy_f);
    logic [31:0] s;
    s        = '0;
    s[AW:0]  = cnt;
    s[16]    = full_f;
    s[17]    = busy_f;
    return s;
  endfunction

  // Full blocks a push even when a pop lands in the same cycle, so the CPU
  // sees a cpu_wait that depends only on registered pointer state.
  always_comb begin
    fifo_empty   = (wptr == rptr);
    fifo_full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    count        = wptr - rptr;
    cmd_wr       = cpu_write && (cpu_addr == ADDR_CMD);
    push         = cmd_wr && !fifo_full;
    cpu_wait     = cmd_wr && fifo_full;
    pop          = cmd_next && !stall && !fifo_empty;
    p0_cmd_valid = !fifo_empty;
    busy         = p0_cmd_valid || blit_active;
    p0_cmd       = fifo_mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      arg0 <= '0;
      arg1 <= '0;
      arg2 <= '0;
    end else if (cpu_write) begin
      case (cpu_addr)
        ADDR_ARG0: arg0 <= cpu_wdata;
        ADDR_ARG1: arg1 <= cpu_wdata;
        ADDR_ARG2: arg2 <= cpu_wdata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is data only; reset discards entries by clearing the pointers.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr[AW-1:0]] <= {cpu_wdata[7:0], arg2, arg1, arg0};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cpu_rdata <= '0;
    end else if (cpu_read) begin
      case (cpu_addr)
        ADDR_ARG0:   cpu_rdata <= arg0;
        ADDR_ARG1:   cpu_rdata <= arg1;
        ADDR_ARG2:   cpu_rdata <= arg2;
        ADDR_STATUS: cpu_rdata <= pack_status(count, fifo_full, busy);
        default:     cpu_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Scoreboard bench for blit_cmd_queue: expected commands are queued on each
// accepted CMD write and compared as the decoder side retires them.
module tb_blit_cmd_queue;

  logic         clock;
  logic         resetn;
  logic         cpu_write;
  logic         cpu_read;
  logic [2:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_wait;
  logic [103:0] p0_cmd;
  logic         p0_cmd_valid;
  logic         cmd_next;
  logic         stall;
  logic         blit_active;

  int n_vec = 0;
  int n_err = 0;
  logic [103:0] sb [$];
  logic [31:0] a0, a1, a2;

  blit_cmd_queue #(.DEPTH(16), .AW(4)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .p0_cmd(p0_cmd), .p0_cmd_valid(p0_cmd_valid),
    .cmd_next(cmd_next), .stall(stall), .blit_active(blit_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [103:0] got, input logic [103:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input logic f, input logic b);
    logic [31:0] s;
    s = '0;
    s[4:0] = cnt[4:0];
    s[16] = f;
    s[17] = b;
    return s;
  endfunction

  // Retirement monitor: compares the head against the oldest expected command.
  always @(negedge clock) begin
    logic [103:0] e;
    if (resetn && cmd_next && !stall) begin
      chk("pop_valid", {103'b0, p0_cmd_valid}, {103'b0, (sb.size() != 0)});
      if (p0_cmd_valid && sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_data", p0_cmd, e);
      end
    end
  end

  task automatic cpu_wr(input logic [2:0] addr, input logic [31:0] data);
    int n;
    cpu_write = 1'b1; cpu_addr = addr; cpu_wdata = data;
    n = 0;
    #1;
    while (cpu_wait && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) chk("wr_timeout", {103'b0, cpu_wait}, 104'd0);
    @(posedge clock); #1;
    cpu_write = 1'b0;
    case (addr)
      3'd0: a0 = data;
      3'd1: a1 = data;
      3'd2: a2 = data;
      3'd3: sb.push_back({data[7:0], a2, a1, a0});
      default: ;
    endcase
  endtask

  task automatic cpu_rd(input logic [2:0] addr, output logic [31:0] data);
    cpu_read = 1'b1; cpu_addr = addr;
    @(posedge clock); #1;
    cpu_read = 1'b0;
    data = cpu_rdata;
  endtask

  task automatic check_status(input string tag, input int cnt, input logic f, input logic b);
    logic [31:0] r;
    cpu_rd(3'd4, r);
    chk(tag, {72'b0, r}, {72'b0, exp_status(cnt, f, b)});
  endtask

  task automatic drain(input int n);
    cmd_next = 1'b1; stall = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
    cmd_next = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [103:0] head;
    cpu_write = 0; cpu_read = 0; cpu_addr = 0; cpu_wdata = 0;
    cmd_next = 0; stall = 0; blit_active = 0;
    a0 = 0; a1 = 0; a2 = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", {103'b0, p0_cmd_valid}, 104'd0);
    chk("rst_rdata", {72'b0, cpu_rdata}, 104'd0);
    chk("rst_wait", {103'b0, cpu_wait}, 104'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Basic command assembly
    cpu_rd(3'd0, r); chk("arg0_rst", {72'b0, r}, 104'd0);
    cpu_wr(3'd0, 32'h0010_0020);
    cpu_wr(3'd1, 32'h0005_0003);
    cpu_wr(3'd2, 32'h0000_0000);
    cpu_wr(3'd3, 32'hFFFF_FF03);
    chk("first_valid", {103'b0, p0_cmd_valid}, 104'd1);
    chk("first_cmd", p0_cmd, 104'h03_00000000_00050003_00100020);
    check_status("status_one", 1, 1'b0, 1'b1);
    cpu_rd(3'd1, r); chk("arg1_rd", {72'b0, r}, 104'h0005_0003);
    cpu_rd(3'd3, r); chk("cmd_rd", {72'b0, r}, 104'd0);
    cpu_wr(3'd5, 32'hDEAD_BEEF);
    cpu_rd(3'd5, r); chk("rsvd_rd", {72'b0, r}, 104'd0);
    drain(1);
    check_status("status_drained", 0, 1'b0, 1'b0);

    // Fill to full, then a blocked CMD write completes after one pop
    for (int i = 0; i < 16; i++) begin
      cpu_wr(3'd0, $urandom);
      cpu_wr(3'd3, 32'h40 + i);
    end
    check_status("status_full", 16, 1'b1, 1'b1);
    cpu_write = 1'b1; cpu_addr = 3'd3; cpu_wdata = 32'h0000_00A5;
    @(negedge clock);
    chk("wait_full", {103'b0, cpu_wait}, 104'd1);
    @(posedge clock); #1;
    chk("wait_hold", {103'b0, cpu_wait}, 104'd1);
    cmd_next = 1'b1;
    @(negedge clock);
    chk("wait_pop_cycle", {103'b0, cpu_wait}, 104'd1);
    @(posedge clock); #1;
    cmd_next = 1'b0;
    chk("wait_release", {103'b0, cpu_wait}, 104'd0);
    @(posedge clock); #1;
    cpu_write = 1'b0;
    sb.push_back({8'hA5, a2, a1, a0});
    check_status("status_refill", 16, 1'b1, 1'b1);
    drain(16);
    check_status("status_empty", 0, 1'b0, 1'b0);

    // Stall holds the head
    for (int i = 0; i < 3; i++) begin
      cpu_wr(3'd2, 32'h1000 * (i + 1));
      cpu_wr(3'd3, 32'h70 + i);
    end
    head = sb[0];
    cmd_next = 1'b1; stall = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("stall_head", p0_cmd, head);
    end
    @(posedge clock); #1;
    check_status("status_stall", 3, 1'b0, 1'b1);
    stall = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    cmd_next = 1'b0;
    chk("stall_sb_empty", 104'(sb.size()), 104'd0);
    check_status("status_after_stall", 0, 1'b0, 1'b0);

    // Pop while empty, and busy from the downstream pipeline
    drain(3);
    check_status("status_empty_pop", 0, 1'b0, 1'b0);
    blit_active = 1'b1;
    check_status("status_blit_busy", 0, 1'b0, 1'b1);
    blit_active = 1'b0;

    // Simultaneous push/pop at count 5, then many iterations across the wrap
    for (int i = 0; i < 5; i++) cpu_wr(3'd3, 32'h80 + i);
    cmd_next = 1'b1;
    cpu_wr(3'd3, 32'h85);
    cmd_next = 1'b0;
    check_status("status_pushpop", 5, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cpu_wr(3'd0, $urandom);
      cpu_wr(3'd1, $urandom);
      cmd_next = 1'b1;
      cpu_wr(3'd3, $urandom_range(0, 255));
      cmd_next = 1'b0;
    end
    check_status("status_wrap", 5, 1'b0, 1'b1);
    drain(5);
    chk("wrap_sb_empty", 104'(sb.size()), 104'd0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 7; i++) cpu_wr(3'd3, 32'h90 + i);
    @(posedge clock); #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", {103'b0, p0_cmd_valid}, 104'd0);
    sb.delete();
    a0 = 0; a1 = 0; a2 = 0;
    @(posedge clock); #2;
    resetn = 1'b1;
    @(posedge clock); #1;
    check_status("status_post_rst", 0, 1'b0, 1'b0);
    cpu_rd(3'd0, r); chk("arg0_post_rst", {72'b0, r}, 104'd0);
    cpu_wr(3'd3, 32'h5A);
    chk("post_rst_valid", {103'b0, p0_cmd_valid}, 104'd1);
    chk("post_rst_head", p0_cmd, {8'h5A, 96'b0});
    drain(1);
    check_status("status_final", 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/blit_cmd_queue.md
Name: blit_cmd_queue

Overview:
- Upstream feeder for the blitter command decoder.
- CPU writes 32-bit argument words, then a command word. Each command write pushes one assembled 104-bit command into an internal FIFO.
- FIFO head is presented as p0_cmd/p0_cmd_valid. An entry is popped when the decoder retires it (cmd_next while not stalled).
- Provides a CPU status register: queue depth, full flag, blitter-busy flag.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
AW, 4, log2(DEPTH); pointer width

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
cpu_write  in  1  CPU write strobe, one cycle per access unless cpu_wait
cpu_read  in  1  CPU read strobe
cpu_addr  in  3  word offset within blitter register window
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  registered read data, valid cycle after cpu_read
cpu_wait  out  1  combinational; CPU must hold the access while high
p0_cmd  out  104  FIFO head: {cmd[7:0], arg2, arg1, arg0}
p0_cmd_valid  out  1  FIFO non-empty
cmd_next  in  1  decoder retires head this cycle
stall  in  1  blitter pipeline stall; pop qualified by !stall
blit_active  in  1  downstream pixel pipeline still active (p5_active)

Behaviour:
- Register map (cpu_addr):
  - 0: ARG0 = {height, width}
  - 1: ARG1 = {y1, x1}
  - 2: ARG2 = {y2, x2}
  - 3: CMD; write pushes
  - 4: STATUS, read-only
  - 5-7: reserved; writes ignored, reads 0
- Writes to ARG0-2 update the argument registers; they take effect the next cycle. They are not cleared by a push, so a command can be reissued with only the CMD write.
- CMD write with FIFO not full: pushes {cpu_wdata[7:0], ARG2, ARG1, ARG0}. Bits 31:8 ignored.
- CMD write with FIFO full: cpu_wait=1 combinationally, no push; the CPU holds the access. The push completes in the first cycle the FIFO is not full.
- cpu_wait is 0 for all other accesses.
- Same-cycle ARG write and CMD push cannot occur (single CPU port).
- Pop = cmd_next & !stall & p0_cmd_valid.
  - Pop while empty is ignored (no pointer change, no underflow).
- Push and pop in the same cycle: both take effect, count unchanged.
  - If full at that cycle, the push is still refused: full blocks push regardless of pop, for deterministic cpu_wait.
- p0_cmd is driven combinationally from storage at the read pointer, stable until the pop edge. The decoder's cmd_next depends combinationally on it, so the output must not glitch while stall=1.
- Latency: push at edge N → p0_cmd_valid=1 after edge N when the FIFO was empty. No bypass.
- Pointers: AW+1 bits, wrap modulo 2·DEPTH.
  - empty = pointers equal.
  - full = low AW bits equal and MSBs differ.
  - count = wptr − rptr, width AW+1; range 0..DEPTH.
- STATUS read value:
  - [AW:0] count
  - [16] full
  - [17] busy = p0_cmd_valid | blit_active
  - all other bits 0
- Reads of 0-2 return the current ARG register; reads of 3 return 0.
- cpu_rdata updates only on cpu_read and holds otherwise.
- Reset (resetn low, asynchronous):
  - pointers 0; p0_cmd_valid=0
  - ARG0-2 = 0; cpu_rdata = 0; cpu_wait = 0
  - FIFO storage not reset; p0_cmd content is don't-care while invalid.
- Reset mid-operation: all queued commands are discarded immediately. The first push after release appears at the head.
- stall held high: no pop occurs; pushes continue until full.

Test Plan:
- Reset, write ARG0=0x0010_0020, ARG1=0x0005_0003, ARG2=0, CMD=0x03 → next cycle p0_cmd_valid=1, p0_cmd=0x03_00000000_00050003_00100020, STATUS count=1, busy=1.
- Push DEPTH=16 commands with cmd_next=0 → 17th CMD write sees cpu_wait=1, STATUS full=1. Pulse cmd_next with stall=0 → push completes next cycle, count stays 16.
- Three commands queued, cmd_next=1 and stall=1 for 4 cycles → count stays 3, head unchanged. Drop stall → one pop per cycle, commands emerge in push order.
- cmd_next=1 with FIFO empty → no state change, count=0, p0_cmd_valid=0.
- Simultaneous CMD push and pop at count=5 → count remains 5. Run 40 push/pop iterations across pointer wrap → order preserved, no data corruption.
- Assert resetn low with 7 entries queued → p0_cmd_valid=0 asynchronously, STATUS reads 0 after release, then a new push is at the head.
